// File: rtl/dht_axil_reg_slave.sv
// AXI4-Lite register slave for the DHT sensor core.
// Four 32-bit registers, selected by address bits [3:2], with byte-strobed writes.
// AW and W are accepted independently and paired in holding registers; the write
// commits on the first edge where both are held. Read and write paths are independent.
//
// Ports:
//   s00_axi_aclk / s00_axi_aresetn : clock, asynchronous active-low reset
//   s00_axi_aw* / w* / b*          : AXI4-Lite write address, data, response channels
//   s00_axi_ar* / r*               : AXI4-Lite read address and data channels
//   reg0_out..reg3_out             : current register contents
//   reg_wr_pulse                   : one-cycle pulse, bit n set when register n is written
module dht_axil_reg_slave #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg0_out,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg1_out,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg2_out,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg3_out,
    output logic [3:0]                      reg_wr_pulse
);

    localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
    localparam int unsigned SW = C_S_AXI_DATA_WIDTH / 8;

    logic          running_q;
    logic          aw_held_q, aw_held_d;
    logic [1:0]    aw_idx_q, aw_idx_d;
    logic          w_held_q, w_held_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [SW-1:0] wstrb_q, wstrb_d;
    logic          bvalid_q, bvalid_d;
    logic          rvalid_q, rvalid_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [3:0]    pulse_q, pulse_d;
    logic [DW-1:0] regs_q [4];
    logic [DW-1:0] regs_d [4];

    logic aw_hs, w_hs, ar_hs, commit;

    // Only the register-select bits of the addresses matter; prot is not used.
    logic unused_inputs;
    assign unused_inputs = ^{s00_axi_awprot, s00_axi_arprot,
                             s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    assign s00_axi_awready = running_q & ~aw_held_q & ~bvalid_q;
    assign s00_axi_wready  = running_q & ~w_held_q & ~bvalid_q;
    assign s00_axi_arready = running_q & ~rvalid_q;

    assign aw_hs  = s00_axi_awvalid & s00_axi_awready;
    assign w_hs   = s00_axi_wvalid & s00_axi_wready;
    assign ar_hs  = s00_axi_arvalid & s00_axi_arready;
    assign commit = aw_held_q & w_held_q;

    always_comb begin
        aw_held_d = aw_held_q;
        aw_idx_d  = aw_idx_q;
        w_held_d  = w_held_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        pulse_d   = '0;
        regs_d    = regs_q;

        if (aw_hs) begin
            aw_held_d = 1'b1;
            aw_idx_d  = s00_axi_awaddr[3:2];
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = s00_axi_wdata;
            wstrb_d  = s00_axi_wstrb;
        end

        // Handshakes cannot coincide with a commit: READY is low while a flag is held.
        if (commit) begin
            for (int k = 0; k < int'(SW); k++) begin
                if (wstrb_q[k]) begin
                    regs_d[aw_idx_q][8*k +: 8] = wdata_q[8*k +: 8];
                end
            end
            pulse_d[aw_idx_q] = 1'b1;
            bvalid_d  = 1'b1;
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
        end else if (bvalid_q && s00_axi_bready) begin
            bvalid_d = 1'b0;
        end

        // Reads sample regs_q, so a same-edge commit returns the pre-write value.
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = regs_q[s00_axi_araddr[3:2]];
        end else if (rvalid_q && s00_axi_rready) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            running_q <= 1'b0;
            aw_held_q <= 1'b0;
            aw_idx_q  <= '0;
            w_held_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            pulse_q   <= '0;
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            running_q <= 1'b1;
            aw_held_q <= aw_held_d;
            aw_idx_q  <= aw_idx_d;
            w_held_q  <= w_held_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            pulse_q   <= pulse_d;
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign s00_axi_bvalid = bvalid_q;
    assign s00_axi_bresp  = 2'b00;
    assign s00_axi_rvalid = rvalid_q;
    assign s00_axi_rdata  = rdata_q;
    assign s00_axi_rresp  = 2'b00;
    assign reg_wr_pulse   = pulse_q;
    assign reg0_out       = regs_q[0];
    assign reg1_out       = regs_q[1];
    assign reg2_out       = regs_q[2];
    assign reg3_out       = regs_q[3];

endmodule

// File: tb/tb_dht_axil_reg_slave.sv
// Self-checking bench for dht_axil_reg_slave: a table of directed write/read vectors
// followed by hand-written sequences for stalls, channel skew, collisions and reset.
module tb_dht_axil_reg_slave;

    logic        clk;
    logic        rst_n;
    logic [3:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] r0, r1, r2, r3;
    logic [3:0]  pulse;

    int checks = 0;
    int errors = 0;

    dht_axil_reg_slave dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rst_n),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awprot  (awprot),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_araddr  (araddr),
        .s00_axi_arprot  (arprot),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready),
        .reg0_out        (r0),
        .reg1_out        (r1),
        .reg2_out        (r2),
        .reg3_out        (r3),
        .reg_wr_pulse    (pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;        // register value after write, or read data
        logic [3:0]  exp_pulse;  // writes only
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] get_reg(input logic [1:0] idx);
        case (idx)
            2'd0:    return r0;
            2'd1:    return r1;
            2'd2:    return r2;
            default: return r3;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [3:0] seen_pulse);
        logic aw_d, w_d, aw_hs, w_hs;
        int   cyc;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        aw_d = 1'b0; w_d = 1'b0; cyc = 0;
        while (!(aw_d && w_d) && cyc < 50) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            tick();
            if (aw_hs) begin awvalid = 1'b0; aw_d = 1'b1; end
            if (w_hs)  begin wvalid = 1'b0;  w_d = 1'b1;  end
            cyc++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        check("aw_accept", {31'd0, aw_d}, 32'd1);
        check("w_accept", {31'd0, w_d}, 32'd1);
        cyc = 0;
        while (!bvalid && cyc < 50) begin
            tick();
            cyc++;
        end
        check("bvalid", {31'd0, bvalid}, 32'd1);
        check("bresp", {30'd0, bresp}, 32'd0);
        seen_pulse = pulse;
        tick();
        check("bvalid_clear", {31'd0, bvalid}, 32'd0);
        check("pulse_clear", {28'd0, pulse}, 32'd0);
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
        logic hs;
        int   cyc;
        araddr = addr; arvalid = 1'b1; rready = 1'b0;
        hs = 1'b0; cyc = 0;
        while (!hs && cyc < 50) begin
            hs = arready;
            tick();
            cyc++;
        end
        arvalid = 1'b0;
        check("ar_accept", {31'd0, hs}, 32'd1);
        check("rvalid", {31'd0, rvalid}, 32'd1);
        check("rresp", {30'd0, rresp}, 32'd0);
        data = rdata;
        rready = 1'b1;
        tick();
        check("rvalid_clear", {31'd0, rvalid}, 32'd0);
        rready = 1'b0;
    endtask

    initial begin
        logic [3:0]  p;
        logic [31:0] d;
        logic [7:0]  a10;

        // wr, addr, data, strb, exp, exp_pulse
        vecs[0]  = '{1'b1, 8'h00, 32'h0000_0001, 4'hF, 32'h0000_0001, 4'b0001};
        vecs[1]  = '{1'b1, 8'h04, 32'h0000_0002, 4'hF, 32'h0000_0002, 4'b0010};
        vecs[2]  = '{1'b1, 8'h08, 32'h0000_0003, 4'hF, 32'h0000_0003, 4'b0100};
        vecs[3]  = '{1'b1, 8'h0C, 32'h0000_0004, 4'hF, 32'h0000_0004, 4'b1000};
        vecs[4]  = '{1'b0, 8'h00, 32'h0,         4'h0, 32'h0000_0001, 4'b0000};
        vecs[5]  = '{1'b0, 8'h04, 32'h0,         4'h0, 32'h0000_0002, 4'b0000};
        vecs[6]  = '{1'b0, 8'h08, 32'h0,         4'h0, 32'h0000_0003, 4'b0000};
        vecs[7]  = '{1'b0, 8'h0C, 32'h0,         4'h0, 32'h0000_0004, 4'b0000};
        vecs[8]  = '{1'b1, 8'h04, 32'h1122_3344, 4'hF, 32'h1122_3344, 4'b0010};
        vecs[9]  = '{1'b1, 8'h05, 32'hAABB_CCDD, 4'h5, 32'h11BB_33DD, 4'b0010};
        vecs[10] = '{1'b0, 8'h06, 32'h0,         4'h0, 32'h11BB_33DD, 4'b0000};
        vecs[11] = '{1'b1, 8'h08, 32'hFFFF_FFFF, 4'h0, 32'h0000_0003, 4'b0100};
        vecs[12] = '{1'b0, 8'h08, 32'h0,         4'h0, 32'h0000_0003, 4'b0000};
        vecs[13] = '{1'b1, 8'h00, 32'h0000_005A, 4'hF, 32'h0000_005A, 4'b0001};
        vecs[14] = '{1'b0, 8'h10, 32'h0,         4'h0, 32'h0000_005A, 4'b0000};
        vecs[15] = '{1'b0, 8'h1C, 32'h0,         4'h0, 32'h0000_0004, 4'b0000};

        rst_n = 1'b0;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_awready", {31'd0, awready}, 32'd0);
        check("rst_bvalid", {31'd0, bvalid}, 32'd0);
        check("rst_rvalid", {31'd0, rvalid}, 32'd0);
        check("rst_reg0", r0, 32'd0);
        check("rst_reg3", r3, 32'd0);
        check("rst_pulse", {28'd0, pulse}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("pre_run_awready", {31'd0, awready}, 32'd0);
        check("pre_run_arready", {31'd0, arready}, 32'd0);
        tick();
        check("run_awready", {31'd0, awready}, 32'd1);
        check("run_wready", {31'd0, wready}, 32'd1);
        check("run_arready", {31'd0, arready}, 32'd1);

        // Table-driven vectors
        for (int i = 0; i < 16; i++) begin
            if (vecs[i].wr) begin
                axi_write(vecs[i].addr[3:0], vecs[i].data, vecs[i].strb, p);
                check($sformatf("vec%0d_pulse", i), {28'd0, p}, {28'd0, vecs[i].exp_pulse});
                check($sformatf("vec%0d_reg", i), get_reg(vecs[i].addr[3:2]), vecs[i].exp);
            end else begin
                axi_read(vecs[i].addr[3:0], d);
                check($sformatf("vec%0d_rdata", i), d, vecs[i].exp);
            end
        end

        // AW arrives 3 cycles ahead of W
        awaddr = 4'h8; awvalid = 1'b1; bready = 1'b1;
        check("skew_awready", {31'd0, awready}, 32'd1);
        tick();
        awvalid = 1'b0;
        check("skew_awready_drop", {31'd0, awready}, 32'd0);
        repeat (3) tick();
        check("skew_awready_held", {31'd0, awready}, 32'd0);
        check("skew_no_bvalid", {31'd0, bvalid}, 32'd0);
        wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1'b1;
        check("skew_wready", {31'd0, wready}, 32'd1);
        tick();
        wvalid = 1'b0;
        check("skew_bvalid_e0", {31'd0, bvalid}, 32'd0);
        tick();
        check("skew_bvalid_e1", {31'd0, bvalid}, 32'd1);
        check("skew_reg2", r2, 32'hDEAD_BEEF);
        check("skew_pulse", {28'd0, pulse}, 32'd4);
        tick();
        check("skew_bvalid_clr", {31'd0, bvalid}, 32'd0);
        bready = 1'b0;

        // BREADY stalled for 10 cycles while a second write waits
        awaddr = 4'hC; wdata = 32'h1234_5678; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        tick();
        wdata = 32'h0000_0077;
        tick();
        for (int i = 0; i < 10; i++) begin
            check("stall_bvalid", {31'd0, bvalid}, 32'd1);
            check("stall_awready", {31'd0, awready}, 32'd0);
            check("stall_wready", {31'd0, wready}, 32'd0);
            tick();
        end
        check("stall_reg3", r3, 32'h1234_5678);
        bready = 1'b1;
        tick();
        check("stall_bvalid_clr", {31'd0, bvalid}, 32'd0);
        awvalid = 1'b0; wvalid = 1'b0;
        axi_write(4'hC, 32'h0000_0077, 4'hF, p);
        check("stall_second_reg3", r3, 32'h0000_0077);
        check("stall_second_pulse", {28'd0, p}, 32'd8);

        // RREADY stalled 5 cycles on a wrapped address
        a10 = 8'h10;
        araddr = a10[3:0]; arvalid = 1'b1; rready = 1'b0;
        check("rstall_arready", {31'd0, arready}, 32'd1);
        tick();
        arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("rstall_rvalid", {31'd0, rvalid}, 32'd1);
            check("rstall_rdata", rdata, 32'h0000_005A);
            check("rstall_arready_low", {31'd0, arready}, 32'd0);
            tick();
        end
        rready = 1'b1;
        tick();
        check("rstall_rvalid_clr", {31'd0, rvalid}, 32'd0);
        rready = 1'b0;

        // Write commit and AR handshake to reg1 on the same edge
        awaddr = 4'h4; wdata = 32'hCAFE_F00D; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        check("coll_awready", {31'd0, awready & wready}, 32'd1);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 4'h4; arvalid = 1'b1;
        check("coll_arready", {31'd0, arready}, 32'd1);
        tick();
        arvalid = 1'b0;
        check("coll_rvalid", {31'd0, rvalid}, 32'd1);
        check("coll_rdata_old", rdata, 32'h11BB_33DD);
        check("coll_reg1_new", r1, 32'hCAFE_F00D);
        check("coll_bvalid", {31'd0, bvalid}, 32'd1);
        check("coll_pulse", {28'd0, pulse}, 32'd2);
        bready = 1'b1; rready = 1'b1;
        tick();
        bready = 1'b0; rready = 1'b0;
        axi_read(4'h4, d);
        check("coll_rdata_new", d, 32'hCAFE_F00D);

        // Reset between AW and W handshakes
        awaddr = 4'h0; awvalid = 1'b1;
        check("mid_awready", {31'd0, awready}, 32'd1);
        tick();
        awvalid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_reg0", r0, 32'd0);
        check("mid_rst_reg2", r2, 32'd0);
        check("mid_rst_awready", {31'd0, awready}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mid_no_bvalid", {31'd0, bvalid}, 32'd0);
            check("mid_no_pulse", {28'd0, pulse}, 32'd0);
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(4'(i * 4), d);
            check($sformatf("mid_read_reg%0d", i), d, 32'd0);
        end
        check("mid_final_pulse", {28'd0, pulse}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dht_axil_reg_slave.md
Name: dht_axil_reg_slave

Overview:
- AXI4-Lite slave register block: the responder end of the AXI4-Lite bus that the VIP master drives in the DHT IP bench.
- Holds four 32-bit control/status registers for the DHT sensor core.
- Exposes the register contents and per-register write pulses to the sensor core.
- Accepts one write and one read transaction at a time, with fully independent AW and W channels.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; bits [3:2] select the register.

Ports:
- s00_axi_aclk  in  1  clock
- s00_axi_aresetn  in  1  reset, asynchronous, active-low
- s00_axi_awaddr  in  4  write address
- s00_axi_awprot  in  3  ignored
- s00_axi_awvalid  in  1  write address valid
- s00_axi_awready  out  1  write address ready
- s00_axi_wdata  in  32  write data
- s00_axi_wstrb  in  4  byte strobes
- s00_axi_wvalid  in  1  write data valid
- s00_axi_wready  out  1  write data ready
- s00_axi_bresp  out  2  write response, always 2'b00
- s00_axi_bvalid  out  1  write response valid
- s00_axi_bready  in  1  write response ready
- s00_axi_araddr  in  4  read address
- s00_axi_arprot  in  3  ignored
- s00_axi_arvalid  in  1  read address valid
- s00_axi_arready  out  1  read address ready
- s00_axi_rdata  out  32  read data
- s00_axi_rresp  out  2  read response, always 2'b00
- s00_axi_rvalid  out  1  read data valid
- s00_axi_rready  in  1  read data ready
- reg0_out..reg3_out  out  32 each  current register values
- reg_wr_pulse  out  4  one-cycle pulse; bit n set when register n is written

Behaviour:
- Clock/reset: one clock, s00_axi_aclk. Reset s00_axi_aresetn is asynchronous, active-low.
- Reset values: while reset is asserted, all registers, rdata, reg_wr_pulse and every VALID/READY output are 0.
- Ready after reset: a registered "running" flag sets on the first clock edge after reset deassertion. All READYs stay 0 until that flag is set.
- Write FSM flags: aw_held and w_held, each with a latched value.
  - AWREADY = running & !aw_held & !BVALID.
  - WREADY = running & !w_held & !BVALID.
  - AW handshake latches awaddr[3:2] and sets aw_held.
  - W handshake latches wdata and wstrb and sets w_held.
  - AW and W may complete in the same cycle or in either order, with any gap between them.
- Write commit: on the first edge where aw_held & w_held are both set:
  - each byte k of the selected register is updated from wdata only where wstrb[k]=1;
  - reg_wr_pulse[idx]=1 for exactly that cycle;
  - BVALID set; aw_held and w_held cleared.
  - Latency: AW and W handshakes at edge E → register updated and BVALID high after edge E+1.
- Write response: BVALID holds until a BVALID&BREADY edge. No new AW or W is accepted while BVALID=1. A W with wstrb=0 still produces a response and a pulse, with the register unchanged.
- Read: ARREADY = running & !RVALID.
  - AR handshake at edge E: RDATA = regs[araddr[3:2]] as sampled before edge E's write commit; RVALID=1 after edge E.
  - RDATA and RVALID hold until an RVALID&RREADY edge.
- Addressing: araddr[1:0] and awaddr[1:0] are ignored. Addresses wrap modulo 16 bytes.
- Read/write collision: a write commit and an AR handshake to the same register on the same edge return the old value. The next read returns the new value.
- Channel independence: read and write paths run independently and concurrently.
- Reset mid-transaction: immediately clears held flags, VALIDs and registers. A partially accepted write is discarded and produces no response.

Test Plan:
- Sequential writes of 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC, then four reads → reads return 0x1..0x4. BRESP/RRESP=0. reg_wr_pulse shows 0001, 0010, 0100, 1000.
- AWVALID to 0x8 asserted 3 cycles before WVALID=0xDEADBEEF → AWREADY drops after its handshake. BVALID rises 1 cycle after the W handshake. reg2_out=0xDEADBEEF.
- Reg1=0x11223344, then write 0xAABBCCDD with wstrb=4'b0101 → reg1 reads 0x11BB33DD.
- BREADY held low for 10 cycles after a write → BVALID stays 1 and AWREADY/WREADY stay 0. A second write is accepted only after the B handshake.
- Read of 0x10 after writing 0x5A to reg0 → returns 0x5A. RREADY held low for 5 cycles → RDATA stable and ARREADY=0.
- Reset pulsed after the AW handshake but before W → no BVALID. All regs read back 0. reg_wr_pulse stays 0.
